// File: rtl/sample_feeder_pkg.sv
// Shared types and constants for the sample_feeder stimulus sequencer.
package sample_feeder_pkg;

  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    DONE
  } feeder_state_t;

endpackage

// File: rtl/sample_feeder_fifo.sv
// Word FIFO for sample_feeder: a push is refused while full, even when a pop
// happens in the same cycle, and the read head comes straight from storage registers.
module sample_feeder_fifo #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned WORD_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [WORD_W-1:0]       wdata,
  input  logic                    pop,
  output logic                    full,
  output logic                    empty,
  output logic [WORD_W-1:0]       head,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sample_feeder.sv
// Replays queued host words onto in_bus for hold+1 cycles each.
// Optional running sum output enabled by defining SAMPLE_FEEDER_SUM_EN.
module sample_feeder
  import sample_feeder_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned HOLD_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [WORD_W-1:0]      wr_data,
  input  logic [HOLD_W-1:0]      hold,
  input  logic                   start,
  output logic                   busy,
  output logic                   drained,
  output logic [$clog2(DEPTH):0] count,
  output logic [WORD_W-1:0]      in_bus,
  output logic                   in_single
`ifdef SAMPLE_FEEDER_SUM_EN
  ,
  output logic [WORD_W-1:0]      sum
`endif
);

  feeder_state_t     state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [WORD_W-1:0] in_bus_q, head;
  logic              busy_q, drained_q, in_single_q;
  logic              pop, full, empty;

  sample_feeder_fifo #(
    .DEPTH (DEPTH),
    .WORD_W(WORD_W)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (wr_valid),
    .wdata(wr_data),
    .pop  (pop),
    .full (full),
    .empty(empty),
    .head (head),
    .count(count)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !empty) begin
          pop     = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (hold_q != '0)  hold_d  = hold_q - 1'b1;
        else if (!empty)   pop     = 1'b1;
        else               state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (pop) hold_d = hold;
  end

  // Status flags are registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      in_bus_q    <= '0;
      in_single_q <= 1'b0;
      busy_q      <= 1'b0;
      drained_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      in_single_q <= pop;
      busy_q      <= (state_d != IDLE);
      drained_q   <= (state_d == DONE);
      if (pop) in_bus_q <= head;
    end
  end

`ifdef SAMPLE_FEEDER_SUM_EN
  logic [WORD_W-1:0] sum_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     sum_q <= '0;
    else if (pop) sum_q <= sum_q + head;
  end

  assign sum = sum_q;
`endif

  assign wr_ready  = !full;
  assign busy      = busy_q;
  assign drained   = drained_q;
  assign in_bus    = in_bus_q;
  assign in_single = in_single_q;

endmodule

// File: tb/tb_sample_feeder.sv
// Directed self-checking bench for sample_feeder (DEPTH=8, HOLD_W=8).
module tb_sample_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic [7:0]  hold;
  logic        start;
  logic        busy;
  logic        drained;
  logic [3:0]  count;
  logic [15:0] in_bus;
  logic        in_single;
`ifdef SAMPLE_FEEDER_SUM_EN
  logic [15:0] sum;
`endif

  int total = 0;
  int bad   = 0;

  sample_feeder #(
    .DEPTH (8),
    .HOLD_W(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .hold     (hold),
    .start    (start),
    .busy     (busy),
    .drained  (drained),
    .count    (count),
    .in_bus   (in_bus),
    .in_single(in_single)
`ifdef SAMPLE_FEEDER_SUM_EN
    ,
    .sum      (sum)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] w);
    wr_valid = 1'b1;
    wr_data  = w;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_bus"},    32'(in_bus),    32'h0);
    chk({tag, "_in_single"}, 32'(in_single), 32'h0);
    chk({tag, "_busy"},      32'(busy),      32'h0);
    chk({tag, "_drained"},   32'(drained),   32'h0);
    chk({tag, "_count"},     32'(count),     32'h0);
    chk({tag, "_wr_ready"},  32'(wr_ready),  32'h1);
  endtask

  initial begin
    rst      = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    hold     = '0;
    start    = 1'b0;
    tick();
    tick();
    chk_reset_outputs("por");
    rst = 1'b1;
    tick();

    // Basic replay, hold=2: words held 3 cycles, drained on cycle 9.
    push(16'h0001);
    push(16'h0002);
    push(16'h0003);
    chk("basic_count", 32'(count), 32'd3);
    hold  = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      chk($sformatf("basic_single_c%0d", c), 32'(in_single),
          (c == 0 || c == 3 || c == 6) ? 32'd1 : 32'd0);
      chk($sformatf("basic_bus_c%0d", c), 32'(in_bus),
          (c < 3) ? 32'h1 : (c < 6) ? 32'h2 : 32'h3);
      chk($sformatf("basic_drained_c%0d", c), 32'(drained), (c == 9) ? 32'd1 : 32'd0);
      chk($sformatf("basic_busy_c%0d", c), 32'(busy), (c <= 9) ? 32'd1 : 32'd0);
      tick();
    end
    chk("basic_bus_retained", 32'(in_bus), 32'h3);
    chk("basic_count_end", 32'(count), 32'd0);

    // Back-to-back, hold=0.
    hold = 8'd0;
    for (int i = 0; i < 4; i++) push(16'h00A0 + 16'(i));
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c <= 5; c++) begin
      if (c < 4) chk($sformatf("b2b_bus_c%0d", c), 32'(in_bus), 32'h00A0 + 32'(c));
      chk($sformatf("b2b_single_c%0d", c), 32'(in_single), (c < 4) ? 32'd1 : 32'd0);
      chk($sformatf("b2b_drained_c%0d", c), 32'(drained), (c == 4) ? 32'd1 : 32'd0);
      chk($sformatf("b2b_busy_c%0d", c), 32'(busy), (c < 5) ? 32'd1 : 32'd0);
      tick();
    end

    // Full FIFO with wr_valid held high across the first pop.
    wr_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_data = 16'h0100 + 16'(i);
      tick();
      chk($sformatf("full_count_%0d", i), 32'(count), 32'(i + 1));
    end
    chk("full_ready_low", 32'(wr_ready), 32'd0);
    wr_data = 16'h0108;
    tick();
    chk("full_refused", 32'(count), 32'd8);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("full_pop_only_count", 32'(count), 32'd7);
    chk("full_pop_only_bus", 32'(in_bus), 32'h0100);
    chk("full_ready_back", 32'(wr_ready), 32'd1);
    tick();
    wr_valid = 1'b0;
    chk("full_pushpop_count", 32'(count), 32'd7);
    chk("full_pushpop_bus", 32'(in_bus), 32'h0101);
    for (int c = 2; c <= 8; c++) begin
      tick();
      chk($sformatf("full_bus_c%0d", c), 32'(in_bus), 32'h0100 + 32'(c));
    end
    tick();
    chk("full_drained", 32'(drained), 32'd1);
    tick();
    chk("full_busy_end", 32'(busy), 32'd0);

    // Late push during HOLD joins the same run.
    hold = 8'd4;
    push(16'h0AAA);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("late_first_bus", 32'(in_bus), 32'h0AAA);
    push(16'h0BBB);
    for (int c = 1; c <= 11; c++) begin
      chk($sformatf("late_single_c%0d", c), 32'(in_single), (c == 5) ? 32'd1 : 32'd0);
      chk($sformatf("late_drained_c%0d", c), 32'(drained), (c == 10) ? 32'd1 : 32'd0);
      chk($sformatf("late_bus_c%0d", c), 32'(in_bus), (c < 5) ? 32'h0AAA : 32'h0BBB);
      tick();
    end
    chk("late_busy_end", 32'(busy), 32'd0);

    // Reset asserted mid-run with words still queued.
    hold = 8'd5;
    push(16'h0011);
    push(16'h0022);
    push(16'h0033);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    #2;
    rst = 1'b1;
    tick();
    chk("postrst_count", 32'(count), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("postrst_start_ignored_busy", 32'(busy), 32'd0);
    chk("postrst_start_ignored_single", 32'(in_single), 32'd0);
    chk("postrst_bus", 32'(in_bus), 32'h0);

`ifdef SAMPLE_FEEDER_SUM_EN
    hold = 8'd0;
    push(16'hFFFF);
    push(16'h0002);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("sum_first", 32'(sum), 32'hFFFF);
    tick();
    chk("sum_wrap", 32'(sum), 32'h0001);
    tick();
    tick();
    chk("sum_kept_after_done", 32'(sum), 32'h0001);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sample_feeder.md
# sample_feeder

Stimulus sequencer that sits directly upstream of the `sample` block and drives its `in_bus` and `in_single` inputs. A host pushes 16-bit words into an internal FIFO over a valid/ready handshake. On `start`, the block replays the queued words onto `in_bus`, holding each for a programmable number of cycles. It pulses `in_single` once per new word and signals `drained` when the queue empties.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `HOLD_W`, 8: width of the `hold` input.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `wr_valid` in 1: host word valid.
- `wr_ready` out 1: FIFO can accept (not full).
- `wr_data` in 16: host word.
- `hold` in HOLD_W: extra cycles each word stays on `in_bus`; sampled at each pop.
- `start` in 1: begin replay; honoured only in IDLE with FIFO non-empty.
- `busy` out 1: FSM not in IDLE.
- `drained` out 1: one-cycle pulse when replay finishes.
- `count` out $clog2(DEPTH)+1: current FIFO occupancy.
- `in_bus` out 16: registered word to downstream `sample`.
- `in_single` out 1: registered one-cycle strobe on each new word.

## Operation
- Push rule: a push occurs when `wr_valid && wr_ready`. `wr_ready = (count != DEPTH)`. There is no full-bypass, so a push while full is refused even if a pop occurs in the same cycle.
- Pop rule: the FSM alone pops. A pop loads the head into `in_bus`, asserts `in_single` for exactly that word's first cycle, and loads `hold` into the hold counter.
- Push and pop in the same cycle: `count` is unchanged and FIFO ordering is preserved.
- FSM states IDLE, HOLD, DONE:
  - IDLE: if `start && count!=0`, pop and go to HOLD. Otherwise stay.
  - HOLD: if counter ≠ 0, decrement. If counter == 0 and FIFO non-empty, pop and stay in HOLD. If counter == 0 and FIFO empty, go to DONE.
  - DONE: assert `drained` for one cycle, then go to IDLE.
- Pushes are allowed in every state. Words pushed during HOLD are replayed in the same run if they arrive before the FIFO-empty check.
- `start` outside IDLE, or with an empty FIFO, is ignored. No queued request results.
- `in_bus` retains the last replayed word after drain until the next pop or reset.
- FIFO pointers wrap modulo DEPTH. `count` ranges 0..DEPTH.
- Reset may assert mid-run. All state clears immediately, and queued words are discarded.
- Reset values: `in_bus`=16'd0, `in_single`=0, `busy`=0, `drained`=0, `count`=0, `wr_ready`=1, state IDLE, hold counter 0.

## Timing
- `start` high at edge k (IDLE, non-empty): the first word appears on `in_bus` with `in_single`=1 after edge k. `busy`=1 from after edge k.
- Each word is visible for exactly `hold`+1 cycles. Consecutive words are back-to-back with no bubble.
- `hold`=0: a new word appears every cycle and `in_single` stays high continuously.
- After the last word's final cycle, there is one cycle in DONE with `drained`=1. `busy` drops the cycle after.
- A push at edge j is visible in `count` after edge j. A pushed word is poppable from edge j+1.
- All outputs are registered. There are no combinational paths from inputs to outputs except `wr_ready`, which derives from registered `count`.

## Configuration
- `SAMPLE_FEEDER_SUM_EN` defined:
  - Adds output `sum` out 16: the running modulo-2^16 sum of every word popped since reset.
  - `sum` updates on the same edge as `in_bus`.
  - `sum` resets to 0 and is not cleared by DONE.
- `SAMPLE_FEEDER_SUM_EN` undefined: the `sum` port and adder are absent, and behaviour is otherwise identical.

## Structure
- Package `sample_feeder_pkg`:
  - `WORD_W`=16.
  - State enum `feeder_state_t` {IDLE, HOLD, DONE}.
- Sub-module `sample_feeder_fifo`:
  - Parameterised by DEPTH and WORD_W.
  - Push/pop ports, `count`, registered read head.
  - Same `clk` and `rst`.
- Top level holds the FSM, hold counter, output registers and optional sum.

## Test plan
- Reset: drive `rst`=0 mid-run with 3 words queued → all outputs at reset values immediately. After release, `count`=0 and `start` is ignored.
- Basic replay: push 16'h0001, 16'h0002, 16'h0003 with `hold`=2, then `start` → each word is held 3 cycles. `in_single` is high on cycles 0, 3 and 6. `drained` pulses on cycle 9. `in_bus` stays 16'h0003.
- Back-to-back: `hold`=0 with 4 words → `in_bus` changes every cycle and `in_single` is high for 4 consecutive cycles.
- Full FIFO: push DEPTH+1 words with `wr_valid` held high → `wr_ready` is 0 after DEPTH pushes. The extra word is not accepted until the first pop. Push and pop in the same cycle keep `count`=DEPTH-1.
- Late push: push 1 word, `start`, `hold`=4, push a second word during HOLD → both words are replayed in the same run, followed by a single `drained` pulse.
- With `SAMPLE_FEEDER_SUM_EN`: replay 16'hFFFF then 16'h0002 → `sum` is 16'hFFFF, then 16'h0001 (wrap).
